// File: rtl/acc_diag_rd_seq.sv
// Accumulator read-address sequencer: walks N_COLS banks row by row (NORMAL)
// or with a per-column skew of c cycles (DIAG) to undo the systolic output skew.
module acc_diag_rd_seq #(
  parameter int N_COLS = 32,
  parameter int ADDR_W = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     mode_i,
  input  logic [ADDR_W-1:0]        base_addr_i,
  input  logic [ADDR_W:0]          num_rows_i,
  input  logic                     stall_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [N_COLS-1:0]        rd_en_o,
  output logic [N_COLS*ADDR_W-1:0] rd_addr_o
);

  localparam int STEP_W = $clog2((2**ADDR_W) + N_COLS);
  localparam logic [ADDR_W:0] MAX_ROWS = (ADDR_W+1)'(2**ADDR_W);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t                    state_q, state_d;
  logic [STEP_W-1:0]         step_q, step_d;
  logic [STEP_W-1:0]         total_q, total_d;
  logic                      mode_q, mode_d;
  logic [ADDR_W-1:0]         base_q, base_d;
  logic [ADDR_W:0]           rows_q, rows_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [N_COLS-1:0]         rd_en_q, rd_en_d;
  logic [N_COLS*ADDR_W-1:0]  rd_addr_q, rd_addr_d;

  logic [ADDR_W:0]           rows_sat;
  logic [STEP_W-1:0]         total_in;
  logic                      issue;

  // Step 0 is issued on the accepting edge, so the issue operands come
  // straight from the inputs while IDLE and from the captured copies after.
  logic [STEP_W-1:0]         iss_step;
  logic                      iss_mode;
  logic [ADDR_W-1:0]         iss_base;
  logic [ADDR_W:0]           iss_rows;
  logic [N_COLS-1:0]         col_en;
  logic [ADDR_W-1:0]         col_addr [N_COLS];

  assign rows_sat = (num_rows_i > MAX_ROWS) ? MAX_ROWS : num_rows_i;
  assign total_in = (rows_sat == '0) ? '0 :
                    mode_i ? STEP_W'(rows_sat) + STEP_W'(N_COLS - 1) : STEP_W'(rows_sat);

  assign iss_step = (state_q == IDLE) ? '0          : step_q;
  assign iss_mode = (state_q == IDLE) ? mode_i      : mode_q;
  assign iss_base = (state_q == IDLE) ? base_addr_i : base_q;
  assign iss_rows = (state_q == IDLE) ? rows_sat    : rows_q;

  for (genvar c = 0; c < N_COLS; c++) begin : g_col
    localparam logic [STEP_W-1:0] COL = STEP_W'(c);
    logic [STEP_W-1:0] off;
    logic [STEP_W-1:0] row_sel;
    assign off         = iss_step - COL;
    assign row_sel     = iss_mode ? off : iss_step;
    assign col_en[c]   = !iss_mode || ((iss_step >= COL) && (off < STEP_W'(iss_rows)));
    assign col_addr[c] = iss_base + row_sel[ADDR_W-1:0];
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    total_d   = total_q;
    mode_d    = mode_q;
    base_d    = base_q;
    rows_d    = rows_q;
    rd_en_d   = '0;
    rd_addr_d = rd_addr_q;
    issue     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          mode_d  = mode_i;
          base_d  = base_addr_i;
          rows_d  = rows_sat;
          total_d = total_in;
          // An empty sequence still spends one RUN cycle, putting done at T+2.
          state_d = RUN;
          if (total_in != '0) begin
            issue  = 1'b1;
            step_d = STEP_W'(1);
          end
        end
      end
      RUN: begin
        if (step_q == total_q) begin
          state_d = FIN;
          step_d  = '0;
        end else if (!stall_i) begin
          issue  = 1'b1;
          step_d = step_q + STEP_W'(1);
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (issue) begin
      rd_en_d = col_en;
      for (int c = 0; c < N_COLS; c++) begin
        if (col_en[c]) rd_addr_d[c*ADDR_W +: ADDR_W] = col_addr[c];
      end
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      step_q    <= '0;
      total_q   <= '0;
      mode_q    <= 1'b0;
      base_q    <= '0;
      rows_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      total_q   <= total_d;
      mode_q    <= mode_d;
      base_q    <= base_d;
      rows_q    <= rows_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rd_en_o   = rd_en_q;
  assign rd_addr_o = rd_addr_q;

endmodule

// File: tb/tb_acc_diag_rd_seq.sv
// Bench for acc_diag_rd_seq: directed scenarios plus random sequences, each
// compared cycle by cycle against a step-list model built from the read rules.
module tb_acc_diag_rd_seq;

  localparam int N_COLS = 4;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 2**ADDR_W;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic                     mode;
  logic [ADDR_W-1:0]        base_addr;
  logic [ADDR_W:0]          num_rows;
  logic                     stall;
  logic                     busy;
  logic                     done;
  logic [N_COLS-1:0]        rd_en;
  logic [N_COLS*ADDR_W-1:0] rd_addr;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [N_COLS-1:0]        en;
    logic [N_COLS*ADDR_W-1:0] addr;
    logic                     busy;
    logic                     done;
    logic                     bubble;
  } cyc_t;

  cyc_t exp_q[$];
  int   model_addr [N_COLS];

  acc_diag_rd_seq #(.N_COLS(N_COLS), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .mode_i     (mode),
    .base_addr_i(base_addr),
    .num_rows_i (num_rows),
    .stall_i    (stall),
    .busy_o     (busy),
    .done_o     (done),
    .rd_en_o    (rd_en),
    .rd_addr_o  (rd_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N_COLS*ADDR_W-1:0] pack_addr();
    logic [N_COLS*ADDR_W-1:0] r;
    for (int c = 0; c < N_COLS; c++) r[c*ADDR_W +: ADDR_W] = ADDR_W'(model_addr[c]);
    return r;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, ".busy"}, 64'(busy), 64'(0));
    chk({tag, ".done"}, 64'(done), 64'(0));
    chk({tag, ".rd_en"}, 64'(rd_en), 64'(0));
    chk({tag, ".rd_addr"}, 64'(rd_addr), 64'(pack_addr()));
  endtask

  // Expected cycles from T+1: issued steps (with stall bubbles placed before
  // step k), then the FIN cycle. Columns not enabled keep their last address.
  task automatic build(input bit m, input int base, input int rows, input int k, input int slen);
    int   rows_eff, total, off;
    cyc_t e;
    exp_q.delete();
    rows_eff = (rows > DEPTH) ? DEPTH : rows;
    total    = (rows_eff == 0) ? 0 : (m ? rows_eff + N_COLS - 1 : rows_eff);
    if (rows_eff == 0) exp_q.push_back('{en: '0, addr: pack_addr(), busy: 1, done: 0, bubble: 0});
    for (int s = 0; s < total; s++) begin
      if (s == k) begin
        for (int b = 0; b < slen; b++)
          exp_q.push_back('{en: '0, addr: pack_addr(), busy: 1, done: 0, bubble: 1});
      end
      e = '{en: '0, addr: '0, busy: 1, done: 0, bubble: 0};
      for (int c = 0; c < N_COLS; c++) begin
        off = m ? s - c : s;
        if (!m || (off >= 0 && off < rows_eff)) begin
          e.en[c]       = 1'b1;
          model_addr[c] = (base + off) % DEPTH;
        end
      end
      e.addr = pack_addr();
      exp_q.push_back(e);
    end
    exp_q.push_back('{en: '0, addr: pack_addr(), busy: 1, done: 1, bubble: 0});
  endtask

  // k: step that gets stalled (>=1), slen: stall cycles, rst_at: entry index
  // during which reset is raised (-1 for none).
  task automatic run_seq(input string tag, input bit m, input int base, input int rows,
                         input int k, input int slen, input int rst_at);
    int n;
    @(negedge clk);
    check_idle({tag, ".idle"});
    start     = 1'b1;
    mode      = m;
    base_addr = ADDR_W'(base);
    num_rows  = (ADDR_W+1)'(rows);
    stall     = 1'($urandom_range(0, 1));
    build(m, base, rows, k, slen);
    n = exp_q.size();
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      chk($sformatf("%s.c%0d.rd_en", tag, j), 64'(rd_en), 64'(exp_q[j].en));
      chk($sformatf("%s.c%0d.rd_addr", tag, j), 64'(rd_addr), 64'(exp_q[j].addr));
      chk($sformatf("%s.c%0d.busy", tag, j), 64'(busy), 64'(exp_q[j].busy));
      chk($sformatf("%s.c%0d.done", tag, j), 64'(done), 64'(exp_q[j].done));
      if (j == rst_at) begin
        rst   = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        for (int c = 0; c < N_COLS; c++) model_addr[c] = 0;
        check_idle({tag, ".after_rst"});
        rst = 1'b0;
        return;
      end
      if (j + 1 < n && exp_q[j+1].bubble) stall = 1'b1;
      else if (j == n - 1)                stall = 1'($urandom_range(0, 1));
      else                                stall = 1'b0;
      start     = 1'($urandom_range(0, 1));
      mode      = 1'($urandom_range(0, 1));
      base_addr = ADDR_W'($urandom);
      num_rows  = (ADDR_W+1)'($urandom);
    end
    start = 1'b0;
  endtask

  initial begin
    int rows, k, rst_at;
    rst       = 1'b1;
    start     = 1'b0;
    mode      = 1'b0;
    base_addr = '0;
    num_rows  = '0;
    stall     = 1'b0;
    for (int c = 0; c < N_COLS; c++) model_addr[c] = 0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    run_seq("normal_b5_r3",   1'b0, 5,   3,   -1, 0, -1);
    run_seq("diag_b0_r2",     1'b1, 0,   2,   -1, 0, -1);
    run_seq("wrap_b126_r4",   1'b0, 126, 4,   -1, 0, -1);
    run_seq("diag_stall",     1'b1, 10,  3,   2,  2, -1);
    run_seq("rows0_normal",   1'b0, 0,   0,   -1, 0, -1);
    run_seq("rows0_diag",     1'b1, 33,  0,   -1, 0, -1);
    run_seq("rst_mid_run",    1'b1, 20,  3,   -1, 0, 2);
    run_seq("after_rst",      1'b1, 7,   1,   -1, 0, -1);
    run_seq("diag_wrap",      1'b1, 125, 5,   1,  1, -1);
    run_seq("sat_normal",     1'b0, 100, 200, 50, 3, -1);
    run_seq("full_diag",      1'b1, 3,   128, 130, 2, -1);

    for (int i = 0; i < 20; i++) begin
      rows   = $urandom_range(0, 140);
      k      = $urandom_range(1, 8);
      rst_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 6) : -1;
      run_seq($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1),
              rows, k, $urandom_range(0, 3), rst_at);
    end

    @(negedge clk);
    check_idle("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
